uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- 16550-compatible UART transmit path: transmit holding FIFO, LCR-driven frame formatter and serializer driving the serial `txd` line.
- Counterpart of the receive path. Sits between the register-map write decode (THR/LCR/FCR) and the `txd` pad.
- Bit timing comes from the external 16x baud-tick pulse produced by the divisor-latch generator.

Parameters:
- PDATA_WIDTH, 8, width of the parallel data bus and of LCR.
- FIFO_DEPTH, 16, transmit FIFO entries. Must be a power of 2.
- CNT_W, 5, width of the FIFO occupancy count. Equals log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- baud_tick_16x  in  1  single-cycle pulse, 16 per bit period
- lcr  in  PDATA_WIDTH  line control register:
  - [1:0] WLS: 5/6/7/8 data bits
  - [2] STB
  - [3] PEN
  - [4] EPS
  - [5] stick parity
  - [6] set break
  - [7] DLAB (ignored here)
- fifo_en  in  1  FCR[0]: 1 = FIFO mode, 0 = single-entry holding register
- fifo_clr  in  1  FCR[2] pulse: flush transmit FIFO
- thr_wdata  in  PDATA_WIDTH  THR write data
- thr_wr  in  1  THR write strobe, one cycle
- txd  out  1  serial output, idle high
- thre  out  1  LSR[5]: FIFO/holding register empty
- temt  out  1  LSR[6]: FIFO empty AND shifter idle
- tx_fifo_count  out  CNT_W  current FIFO occupancy
- tx_overrun  out  1  one-cycle pulse when a write is dropped because the FIFO is full

Behaviour:
- Reset values (synchronous, applies on any cycle including mid-frame):
  - txd=1, thre=1, temt=1, tx_fifo_count=0, tx_overrun=0
  - FIFO pointers cleared, FSM=IDLE, tick counter=0, bit counter=0
- Effective depth is FIFO_DEPTH when fifo_en=1, and 1 when fifo_en=0.
- A change of fifo_en flushes the FIFO exactly as fifo_clr does.
- Writes:
  - thr_wr with occupancy < effective depth → entry is pushed and the count increments on the next edge.
  - thr_wr when full → data dropped, tx_overrun pulses for one cycle.
  - Full with a pop in the same cycle → the write is accepted and the count is unchanged.
- fifo_clr:
  - Empties the FIFO next cycle; count=0.
  - fifo_clr has priority over a simultaneous thr_wr, which is dropped without tx_overrun.
  - The character already in the shifter completes normally.
- FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit tick counter advances only on baud_tick_16x.
- IDLE: txd=1.
  - On a baud_tick_16x with the FIFO non-empty: pop head into the shift register and latch lcr[5:0] for the whole frame.
  - Then go to START, tick counter=0.
  - A mid-frame LCR change therefore does not affect the current frame.
- START: txd=0 for 16 ticks, then go to DATA with bit counter=0.
- DATA:
  - txd = shift[0], LSB first, 16 ticks per bit.
  - After 5+WLS bits: go to PARITY if PEN=1, else STOP.
- PARITY: 16 ticks; parity bit value is:
  - stick=0, EPS=1 (even): XOR of the data bits
  - stick=0, EPS=0 (odd): inverse of that XOR
  - stick=1: the inverse of EPS (EPS=1 → 0, EPS=0 → 1)
- STOP: txd=1.
  - Duration is 16 ticks when STB=0.
  - When STB=1: 24 ticks if WLS=00, else 32 ticks.
  - At the end, return to IDLE. If the FIFO is non-empty, the same tick may start the next frame, giving back-to-back frames with no idle gap.
- Break: while live lcr[6]=1, txd is forced 0 in every state; the FSM keeps running. On deassertion, txd returns to the FSM value in the same cycle.
- Flag timing (registered, 1-cycle latency):
  - thre = (occupancy==0)
  - temt = thre AND FSM==IDLE
- Data bits above WLS in thr_wdata are ignored.

Test Plan:
- Test 1 (8N1 frame):
  - Stimulus: lcr=0x03, fifo_en=1, write 0x55.
  - Response: after the first tick, txd holds each bit for 16 ticks in the sequence 0,1,0,1,0,1,0,1,0,1.
  - thre=1 one cycle after the pop; temt=1 one cycle after STOP ends (160 ticks total).
- Test 2 (7-bit even parity, 2 stop):
  - Stimulus: lcr=0x1E, write 0x6B.
  - Response: 7 data bits 1,1,0,1,0,1,1 (ones=5), parity=1, then stop=1 for 32 ticks.
- Test 3 (5-bit stick parity, 1.5 stop):
  - Stimulus: lcr=0x2C (5 bits, PEN, stick, EPS=0), write 0x1F.
  - Response: data 1,1,1,1,1, parity=1, stop high for exactly 24 ticks.
- Test 4 (FIFO fill and overrun):
  - Stimulus: 17 back-to-back writes 0x00..0x10 with no baud ticks.
  - Response: tx_fifo_count=16, tx_overrun pulses exactly on the 17th write.
  - After enabling ticks: 16 frames 0x00..0x0F go out with no idle gap between frames.
- Test 5 (clear and break mid-frame):
  - Stimulus: start frame 0xA5; assert fifo_clr while 3 entries are queued; set lcr[6]=1 for 40 ticks mid-DATA.
  - Response: count=0 next cycle; txd=0 throughout the break; 0xA5 frame ends on schedule; no further frames.
- Test 6 (non-FIFO mode and reset mid-frame):
  - Stimulus: fifo_en=0, two writes while idle with no ticks.
  - Response: second write raises tx_overrun.
  - Then assert reset mid-DATA: next cycle txd=1, thre=1, temt=1, tx_fifo_count=0.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// 16550-style transmit path: holding FIFO, LCR-driven frame formatter and serializer.
// Bit timing comes from the external 16x baud-tick pulse.
module uart_tx_serializer #(
    parameter int unsigned PDATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   baud_tick_16x,
    input  logic [PDATA_WIDTH-1:0] lcr,
    input  logic                   fifo_en,
    input  logic                   fifo_clr,
    input  logic [PDATA_WIDTH-1:0] thr_wdata,
    input  logic                   thr_wr,
    output logic                   txd,
    output logic                   thre,
    output logic                   temt,
    output logic [CNT_W-1:0]       tx_fifo_count,
    output logic                   tx_overrun
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [PDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   fifo_en_q;
    logic                   overrun_q, overrun_d;
    logic                   thre_q, thre_d;
    logic                   temt_q, temt_d;

    // Serializer state
    state_e                 state_q, state_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [PDATA_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]             frame_cfg_q, frame_cfg_d;
    logic                   par_q, par_d;

    logic                   flush;
    logic                   fifo_empty;
    logic                   eff_full;
    logic                   push;
    logic                   pop;
    logic                   tick_last;
    logic                   stop_done;
    logic [2:0]             last_bit;
    logic                   txd_fsm;
    logic [PDATA_WIDTH-1:0] head;
    logic [PDATA_WIDTH-1:0] head_masked;
    logic                   unused_lcr;

    assign unused_lcr = lcr[PDATA_WIDTH-1];

    // A change of fifo_en empties the FIFO just like an explicit clear.
    assign flush      = fifo_clr | (fifo_en ^ fifo_en_q);
    assign fifo_empty = (count_q == '0);
    assign eff_full   = fifo_en ? (count_q == CNT_W'(FIFO_DEPTH)) : !fifo_empty;
    assign tick_last  = (tick_cnt_q == 4'd15);
    assign last_bit   = 3'd4 + {1'b0, frame_cfg_q[1:0]};

    always_comb begin
        head = mem_q[rd_ptr_q];
        for (int i = 0; i < PDATA_WIDTH; i++) begin
            head_masked[i] = head[i] & (i < 5 + int'(lcr[1:0]));
        end
    end

    // STOP length in ticks: 16, or 24/32 with STB set; bit_cnt counts 16-tick halves here.
    always_comb begin
        if (!frame_cfg_q[2]) begin
            stop_done = tick_last;
        end else if (frame_cfg_q[1:0] == 2'b00) begin
            stop_done = bit_cnt_q[0] && (tick_cnt_q == 4'd7);
        end else begin
            stop_done = bit_cnt_q[0] && tick_last;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_cfg_d = frame_cfg_q;
        par_d       = par_q;
        pop         = 1'b0;

        if (baud_tick_16x) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            case (state_q)
                StIdle: begin
                    tick_cnt_d = '0;
                    pop        = !fifo_empty;
                end
                StStart: begin
                    if (tick_last) begin
                        state_d    = StData;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                StData: begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        if (bit_cnt_q == last_bit) begin
                            state_d   = frame_cfg_q[3] ? StParity : StStop;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shift_d   = shift_q >> 1;
                        end
                    end
                end
                StParity: begin
                    if (tick_last) begin
                        state_d    = StStop;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                StStop: begin
                    if (stop_done) begin
                        state_d    = StIdle;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        pop        = !fifo_empty;
                    end else if (tick_last) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end

        // Frame format and parity are captured at pop so later LCR writes cannot disturb it.
        if (pop) begin
            state_d     = StStart;
            tick_cnt_d  = '0;
            bit_cnt_d   = '0;
            shift_d     = head_masked;
            frame_cfg_d = lcr[3:0];
            par_d       = lcr[5] ? !lcr[4] : (lcr[4] ? ^head_masked : !(^head_masked));
        end
    end

    always_comb begin
        push      = thr_wr && !flush && (!eff_full || pop);
        overrun_d = thr_wr && !flush && eff_full && !pop;
        wr_ptr_d  = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d   = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        thre_d = fifo_empty;
        temt_d = fifo_empty && (state_q == StIdle);
    end

    always_comb begin
        case (state_q)
            StStart:  txd_fsm = 1'b0;
            StData:   txd_fsm = shift_q[0];
            StParity: txd_fsm = par_q;
            default:  txd_fsm = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_cfg_q <= '0;
            par_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            thre_q      <= 1'b1;
            temt_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_cfg_q <= frame_cfg_d;
            par_q       <= par_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            thre_q      <= thre_d;
            temt_q      <= temt_d;
        end
    end

    // Tracks the mode even through reset so leaving reset never looks like a mode change.
    always_ff @(posedge clk) begin
        fifo_en_q <= fifo_en;
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= thr_wdata;
        end
    end

    // Break overrides the line from the live LCR without stopping the serializer.
    assign txd           = lcr[6] ? 1'b0 : txd_fsm;
    assign thre          = thre_q;
    assign temt          = temt_q;
    assign tx_fifo_count = count_q;
    assign tx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-format table, directed FIFO/clear/break/reset
// sequences and a randomized run against a tick-counting reference model.
module tb_uart_tx_serializer;

    localparam int unsigned PW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          baud_tick_16x = 1'b0;
    logic [PW-1:0] lcr = 8'h03;
    logic          fifo_en = 1'b1;
    logic          fifo_clr = 1'b0;
    logic [PW-1:0] thr_wdata = '0;
    logic          thr_wr = 1'b0;
    logic          txd;
    logic          thre;
    logic          temt;
    logic [CW-1:0] tx_fifo_count;
    logic          tx_overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .PDATA_WIDTH(PW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_tick_16x(baud_tick_16x),
        .lcr          (lcr),
        .fifo_en      (fifo_en),
        .fifo_clr     (fifo_clr),
        .thr_wdata    (thr_wdata),
        .thr_wr       (thr_wr),
        .txd          (txd),
        .thre         (thre),
        .temt         (temt),
        .tx_fifo_count(tx_fifo_count),
        .tx_overrun   (tx_overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending bytes plus "ticks elapsed since the pop" of the frame.
    logic [7:0] mq[$];
    bit         m_busy = 1'b0;
    int         m_e, m_len, m_n, m_stop;
    bit         m_pen, m_par;
    logic [7:0] m_data;
    bit         m_fen_prev;
    bit         m_thre = 1'b1, m_temt = 1'b1, m_ovr = 1'b0;

    function automatic void model_start(input logic [7:0] d);
        logic [8:0] mask9;
        m_n    = 5 + int'(lcr[1:0]);
        mask9  = (9'd1 << m_n) - 9'd1;
        m_data = d & mask9[7:0];
        m_pen  = lcr[3];
        m_par  = lcr[5] ? !lcr[4] : (lcr[4] ? ^m_data : !(^m_data));
        m_stop = lcr[2] ? ((lcr[1:0] == 2'b00) ? 24 : 32) : 16;
        m_len  = 16 * (1 + m_n + int'(lcr[3])) + m_stop;
        m_e    = 0;
        m_busy = 1'b1;
    endfunction

    function automatic logic exp_txd();
        int seg;
        if (lcr[6]) return 1'b0;
        if (!m_busy) return 1'b1;
        seg = m_e / 16;
        if (seg == 0) return 1'b0;
        if (seg <= m_n) return m_data[seg-1];
        if (m_pen && seg == m_n + 1) return m_par;
        return 1'b1;
    endfunction

    function automatic void model_step();
        bit nthre, ntemt, flush;
        int depth;
        nthre = (mq.size() == 0);
        ntemt = nthre && !m_busy;
        if (reset) begin
            mq.delete();
            m_busy     = 1'b0;
            m_e        = 0;
            m_thre     = 1'b1;
            m_temt     = 1'b1;
            m_ovr      = 1'b0;
            m_fen_prev = fifo_en;
            return;
        end
        m_thre = nthre;
        m_temt = ntemt;
        m_ovr  = 1'b0;
        if (baud_tick_16x) begin
            if (m_busy) begin
                m_e++;
                if (m_e == m_len) m_busy = 1'b0;
            end
            if (!m_busy && mq.size() > 0) model_start(mq.pop_front());
        end
        flush = fifo_clr || (fifo_en != m_fen_prev);
        depth = fifo_en ? DEPTH : 1;
        if (flush) begin
            mq.delete();
        end else if (thr_wr) begin
            if (mq.size() < depth) mq.push_back(thr_wdata);
            else m_ovr = 1'b1;
        end
        m_fen_prev = fifo_en;
    endfunction

    // Lockstep comparison of every output against the model, just after each edge.
    always begin
        @(posedge clk);
        model_step();
        #1;
        check("lockstep txd", int'(txd), int'(exp_txd()));
        check("lockstep count", int'(tx_fifo_count), mq.size());
        check("lockstep thre", int'(thre), int'(m_thre));
        check("lockstep temt", int'(temt), int'(m_temt));
        check("lockstep overrun", int'(tx_overrun), int'(m_ovr));
    end

    task automatic tick1();
        @(negedge clk);
        baud_tick_16x = 1'b1;
        @(negedge clk);
        baud_tick_16x = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        thr_wr    = 1'b1;
        thr_wdata = d;
        @(negedge clk);
        thr_wr    = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  lcr;
        logic [7:0]  data;
        int          nseg;
        logic [15:0] segs;
        int          stop;
    } vec_t;

    vec_t vecs[7];
    logic lv[0:511];

    initial begin
        int e;
        int bad;
        int t;

        // Level of each 16-tick segment, bit 0 = start bit.
        vecs[0] = '{8'h03, 8'h55, 9,  16'h00AA, 16};
        vecs[1] = '{8'h1E, 8'h6B, 9,  16'h01D6, 32};
        vecs[2] = '{8'h2C, 8'h1F, 7,  16'h007E, 24};
        vecs[3] = '{8'h1B, 8'hFF, 10, 16'h01FE, 16};
        vecs[4] = '{8'h09, 8'hC3, 8,  16'h0086, 16};
        vecs[5] = '{8'h07, 8'h80, 9,  16'h0100, 32};
        vecs[6] = '{8'h34, 8'hEA, 6,  16'h0014, 24};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset txd", int'(txd), 1);
        check("reset thre", int'(thre), 1);
        check("reset temt", int'(temt), 1);
        check("reset count", int'(tx_fifo_count), 0);
        check("reset overrun", int'(tx_overrun), 0);

        // Frame formats
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            lcr = vecs[v].lcr;
            wr(vecs[v].data);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d queued temt", v), int'(temt), 0);
            tick1();
            e = 0;
            while (temt == 1'b0 && e < 400) begin
                lv[e] = txd;
                tick1();
                e++;
            end
            check($sformatf("v%0d frame ticks", v), e, 16 * vecs[v].nseg + vecs[v].stop);
            for (int s = 0; s < vecs[v].nseg; s++) begin
                bad = 0;
                for (int k = 0; k < 16; k++) begin
                    if (16 * s + k < e && lv[16*s+k] !== vecs[v].segs[s]) bad++;
                end
                check($sformatf("v%0d seg%0d wrong ticks", v, s), bad, 0);
            end
            bad = 0;
            for (int k = 16 * vecs[v].nseg; k < e; k++) begin
                if (lv[k] !== 1'b1) bad++;
            end
            check($sformatf("v%0d stop wrong ticks", v), bad, 0);
        end

        // FIFO fill and overrun, then back-to-back drain
        @(negedge clk);
        lcr = 8'h03;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i > 0) check($sformatf("fill overrun w%0d", i - 1), int'(tx_overrun), 0);
            thr_wr    = 1'b1;
            thr_wdata = 8'(i);
        end
        @(negedge clk);
        thr_wr = 1'b0;
        check("fill overrun w16", int'(tx_overrun), 1);
        check("fill count", int'(tx_fifo_count), 16);
        @(negedge clk);
        check("overrun one cycle", int'(tx_overrun), 0);
        tick1();
        t = 1;
        while (temt == 1'b0 && t < 3000) begin
            tick1();
            t++;
        end
        check("drain 16 frames ticks", t, 1 + 16 * 160);

        // Clear and break mid-frame
        wr(8'hA5);
        tick1();
        wr(8'h01);
        wr(8'h02);
        wr(8'h03);
        check("clr pre count", int'(tx_fifo_count), 3);
        @(negedge clk);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        check("clr count", int'(tx_fifo_count), 0);
        e = 0;
        repeat (20) begin
            tick1();
            e++;
        end
        @(negedge clk);
        lcr = 8'h43;
        #1;
        check("break immediate", int'(txd), 0);
        bad = 0;
        repeat (40) begin
            tick1();
            e++;
            if (txd !== 1'b0) bad++;
        end
        check("break held ticks", bad, 0);
        @(negedge clk);
        lcr = 8'h03;
        while (temt == 1'b0 && e < 400) begin
            tick1();
            e++;
        end
        check("A5 frame ticks", e, 160);
        repeat (50) tick1();
        check("no frame after clr temt", int'(temt), 1);
        check("no frame after clr count", int'(tx_fifo_count), 0);

        // Single-entry mode and reset mid-frame
        @(negedge clk);
        fifo_en = 1'b0;
        repeat (2) @(negedge clk);
        wr(8'h11);
        check("nofifo w1 overrun", int'(tx_overrun), 0);
        check("nofifo w1 count", int'(tx_fifo_count), 1);
        wr(8'h22);
        check("nofifo w2 overrun", int'(tx_overrun), 1);
        check("nofifo w2 count", int'(tx_fifo_count), 1);
        tick1();
        repeat (20) tick1();
        check("mid-data busy", int'(temt), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset txd", int'(txd), 1);
        check("midreset thre", int'(thre), 1);
        check("midreset temt", int'(temt), 1);
        check("midreset count", int'(tx_fifo_count), 0);

        // Randomized traffic against the model
        @(negedge clk);
        fifo_en = 1'b1;
        for (int c = 0; c < 14000; c++) begin
            @(negedge clk);
            baud_tick_16x = ($urandom % 3) == 0;
            thr_wr        = ($urandom % 6) == 0;
            thr_wdata     = 8'($urandom);
            fifo_clr      = ($urandom % 700) == 0;
            reset         = ($urandom % 4000) == 0;
            if (($urandom % 400) == 0) begin
                lcr      = 8'($urandom);
                lcr[6]   = ($urandom % 6) == 0;
            end
            if (($urandom % 2500) == 0) fifo_en = !fifo_en;
        end
        @(negedge clk);
        baud_tick_16x = 1'b0;
        thr_wr        = 1'b0;
        fifo_clr      = 1'b0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
